// File: rtl/alu_op_sequencer.sv
// Multi-cycle issuer for the combinational ALU: accepts a request, stages operand A
// through Y, captures the ALU result into Z and returns it over a valid/ready channel.
module alu_op_sequencer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned OPW    = 4,
  parameter int unsigned MAX_OP = 2
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [OPW-1:0]   req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD_Y, EXEC, RESP} state_t;

  localparam logic [OPW-1:0] MAX_OP_C = OPW'(MAX_OP);

  state_t           state, state_nx;
  logic [WIDTH-1:0] y_reg, z_reg, b_reg, a_hold;
  logic [WIDTH-1:0] alu_b_reg;
  logic [OPW-1:0]   op_reg, alu_op_reg;
  logic             illegal;

  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= IDLE;
      y_reg      <= '0;
      z_reg      <= '0;
      b_reg      <= '0;
      a_hold     <= '0;
      op_reg     <= '0;
      illegal    <= 1'b0;
      alu_b_reg  <= '0;
      alu_op_reg <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            a_hold  <= req_a;
            b_reg   <= req_b;
            op_reg  <= req_op;
            illegal <= (req_op > MAX_OP_C);
          end
        end
        LOAD_Y: begin
          // Y doubles as the registered ALU A port; B/op are staged alongside so
          // all three ALU inputs change together on entry to EXEC and then hold.
          y_reg      <= a_hold;
          alu_b_reg  <= b_reg;
          alu_op_reg <= op_reg;
        end
        EXEC: z_reg <= alu_result;
        RESP: ;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = LOAD_Y;
      LOAD_Y:  state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign alu_a       = y_reg;
  assign alu_b       = alu_b_reg;
  assign alu_op      = alu_op_reg;
  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign rsp_valid   = (state == RESP);
  assign rsp_data    = rsp_valid ? z_reg : '0;
  assign rsp_zero    = rsp_valid && (z_reg == '0);
  assign rsp_illegal = rsp_valid && illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed cases from the plan plus random traffic,
// with a behavioural ALU on the DUT's ALU port and a separate response monitor.
module tb_alu_op_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 4;

  logic             clock = 1'b0;
  logic             clear;
  logic             req_valid, req_ready;
  logic [WIDTH-1:0] req_a, req_b;
  logic [OPW-1:0]   req_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [OPW-1:0]   alu_op;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero, rsp_illegal, busy;

  alu_op_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .MAX_OP(2)) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  always #5 clock = ~clock;

  // The ALU the sequencer drives: 0 OR, 1 AND, 2 NOT, anything else returns 0.
  always_comb begin
    case (alu_op)
      4'd0:    alu_result = alu_a | alu_b;
      4'd1:    alu_result = alu_a & alu_b;
      4'd2:    alu_result = ~alu_a;
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             illegal;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  bit   b2b_mode = 0;
  bit   have_last = 0;
  int   last_acc = 0;

  always @(posedge clock) cycle <= cycle + 1;

  function automatic exp_t ref_model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [OPW-1:0] op);
    exp_t e;
    e.a = a; e.b = b; e.op = op;
    e.illegal = (int'(op) > 2);
    if (op == 0)      e.data = a | b;
    else if (op == 1) e.data = a & b;
    else if (op == 2) e.data = ~a;
    else              e.data = 0;
    e.zero = (e.data == 0);
    return e;
  endfunction

  task automatic check(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: clear aborts in-flight work, responses are popped, accepts are pushed.
  always @(negedge clock) begin
    if (clear) begin
      exp_q.delete();
      have_last = 0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got data 0x%08h, expected no response", rsp_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
          check("rsp_illegal", 32'(rsp_illegal), 32'(e.illegal));
          check("alu_a_held", alu_a, e.a);
          check("alu_b_held", alu_b, e.b);
          check("alu_op_held", 32'(alu_op), 32'(e.op));
        end
      end
      if (req_valid && req_ready) begin
        exp_q.push_back(ref_model(req_a, req_b, req_op));
        if (b2b_mode) begin
          if (have_last) check("issue_interval", 32'(cycle - last_acc), 32'd4);
          last_acc  = cycle;
          have_last = 1;
        end
      end
    end
  end

  task automatic issue(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [OPW-1:0] op);
    bit ok = 0;
    @(posedge clock); #1;
    req_valid = 1; req_a = a; req_b = b; req_op = op;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout: req_ready got 0, expected 1 within 50 cycles");
    end
    @(posedge clock); #1;
    req_valid = 0;
    req_a = $urandom; req_b = $urandom; req_op = OPW'($urandom);
  endtask

  task automatic wait_idle(int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!busy && exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy got %0d, expected 0 (queue %0d)", busy, exp_q.size());
    end
  endtask

  initial begin
    clear = 1; req_valid = 0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1;
    repeat (2) @(posedge clock);
    #1 clear = 0;
    @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);

    // OR, with a check that the response is not early.
    issue(32'h0000_00F0, 32'h0000_000F, 4'd0);
    check("no_early_rsp", 32'(rsp_valid), 32'd0);
    wait_idle(20);
    issue(32'hFFFF_0000, 32'h0000_FFFF, 4'd1);
    wait_idle(20);

    // NOT with back-pressure.
    rsp_ready = 0;
    issue(32'h1234_5678, 32'h0, 4'd2);
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        if (rsp_valid) begin seen = 1; break; end
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL bp_rsp_timeout: rsp_valid got 0, expected 1");
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", rsp_data, 32'hEDCB_A987);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clock); #1 rsp_ready = 1;
    @(posedge clock); #1;
    check("bp_release_idle", 32'(req_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);

    // Illegal op, then a legal one.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7);
    wait_idle(20);
    issue(32'h0000_0003, 32'h0000_0005, 4'd1);
    wait_idle(20);

    // Reset during EXEC.
    issue(32'h1, 32'h2, 4'd0);
    @(posedge clock); #1;
    check("exec_alu_a", alu_a, 32'h1);
    check("exec_alu_b", alu_b, 32'h2);
    check("exec_busy", 32'(busy), 32'd1);
    clear = 1;
    @(posedge clock); #1 clear = 0;
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_alu_a", alu_a, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("abort_rsp_data", rsp_data, 32'd0);

    // Back-to-back with req_valid held and operands changing every cycle.
    b2b_mode = 1;
    rsp_ready = 1;
    @(posedge clock); #1;
    req_valid = 1;
    for (int i = 0; i < 24; i++) begin
      req_a = $urandom; req_b = $urandom; req_op = OPW'($urandom_range(0, 3));
      @(posedge clock); #1;
    end
    req_valid = 0;
    wait_idle(20);
    b2b_mode = 0;

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_a     = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      req_b     = $urandom;
      req_op    = ($urandom_range(0, 4) == 0) ? OPW'($urandom) : OPW'($urandom_range(0, 2));
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(posedge clock); #1;
    end
    req_valid = 0;
    rsp_ready = 1;
    wait_idle(50);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
